// File: rtl/ras_stack_pkg.sv
// ras_stack_pkg: shared fetch-side types for the return-address stack.
package cva5_types;
   localparam int RAS_DEPTH_DEFAULT = 8;
   typedef logic [$clog2(RAS_DEPTH_DEFAULT)-1:0] ras_index_t;
   typedef struct packed {
      logic        push;
      logic        pop;
      logic [31:0] new_addr;
      logic        branch_fetched;
      logic        branch_retired;
      logic        flush;
   } ras_interface_t;
endpackage

// File: rtl/ras_stack_lutram.sv
// lutram_1w_1r: unreset distributed RAM, one sync write port, one async read port.
module lutram_1w_1r #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we_i) mem[waddr_i] <= wdata_i;
   assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with inflight-branch tracking.
// Define RAS_CHECKPOINT_EN to let flush restore the stack pointer/count from a checkpoint.
module ras_stack
   import cva5_types::*;
#(
   parameter int RAS_DEPTH    = RAS_DEPTH_DEFAULT,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] new_addr,
   input  logic        branch_fetched,
   input  logic        branch_retired,
   input  logic        flush,
   output logic [31:0] addr
);
   localparam int IW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam int FW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
   localparam logic [FW-1:0] FMAX = FW'(MAX_INFLIGHT);
   ras_interface_t req;
   logic [IW-1:0] read_index_q, read_index_d, wr_index;
   logic [CW-1:0] count_q, count_d;
   logic [FW-1:0] inflight_q, inflight_d;
   logic [31:0]   rd_data;
   logic          we;
   assign req = '{push: push, pop: pop, new_addr: new_addr, branch_fetched: branch_fetched,
                  branch_retired: branch_retired, flush: flush};
`ifdef RAS_CHECKPOINT_EN
   logic [IW-1:0] ckpt_index_q;
   logic [CW-1:0] ckpt_count_q;
   // Snapshot is taken from pre-update state, at the oldest unretired branch.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ckpt_index_q <= '0;
         ckpt_count_q <= '0;
      end else if (req.branch_fetched && !req.flush && inflight_q == '0) begin
         ckpt_index_q <= read_index_q;
         ckpt_count_q <= count_q;
      end
`endif
   always_comb begin
      read_index_d = read_index_q;
      count_d      = count_q;
      inflight_d   = inflight_q;
      if (req.push && req.pop) count_d = (count_q == '0) ? CW'(1) : count_q;
      else if (req.push) begin
         read_index_d = read_index_q + IW'(1);
         count_d      = (count_q == FULL) ? FULL : count_q + CW'(1);
      end else if (req.pop && count_q != '0) begin
         read_index_d = read_index_q - IW'(1);
         count_d      = count_q - CW'(1);
      end
      if (req.branch_fetched && !req.branch_retired && inflight_q != FMAX)
         inflight_d = inflight_q + FW'(1);
      else if (req.branch_retired && !req.branch_fetched && inflight_q != '0)
         inflight_d = inflight_q - FW'(1);
      if (req.flush) begin
         inflight_d   = '0;
`ifdef RAS_CHECKPOINT_EN
         read_index_d = (inflight_q != '0) ? ckpt_index_q : read_index_q;
         count_d      = (inflight_q != '0) ? ckpt_count_q : count_q;
`else
         read_index_d = read_index_q;
         count_d      = count_q;
`endif
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         read_index_q <= '0;
         count_q      <= '0;
         inflight_q   <= '0;
      end else begin
         read_index_q <= read_index_d;
         count_q      <= count_d;
         inflight_q   <= inflight_d;
      end
   // Push+pop replaces the top in place; a lone push writes the next slot.
   assign wr_index = req.pop ? read_index_q : read_index_q + IW'(1);
   assign we       = req.push && !req.flush;
   lutram_1w_1r #(.WIDTH(32), .DEPTH(RAS_DEPTH)) u_mem (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (wr_index),
      .wdata_i (req.new_addr),
      .raddr_i (read_index_q),
      .rdata_o (rd_data)
   );
   assign addr = (count_q == '0) ? 32'h0 : rd_data;
endmodule

// File: tb/tb_ras_stack.sv
// tb_ras_stack: directed self-checking bench for ras_stack (RAS_DEPTH=8, MAX_INFLIGHT=4).
module tb_ras_stack;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        push = 1'b0, pop = 1'b0, branch_fetched = 1'b0, branch_retired = 1'b0, flush = 1'b0;
   logic [31:0] new_addr = '0;
   logic [31:0] addr;
   int          total = 0, passed = 0;
   ras_stack #(.RAS_DEPTH(8), .MAX_INFLIGHT(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .push           (push),
      .pop            (pop),
      .new_addr       (new_addr),
      .branch_fetched (branch_fetched),
      .branch_retired (branch_retired),
      .flush          (flush),
      .addr           (addr)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask
   task automatic step(input logic pu, input logic po, input logic [31:0] a,
                       input logic bf, input logic br, input logic fl);
      push = pu; pop = po; new_addr = a; branch_fetched = bf; branch_retired = br; flush = fl;
      @(posedge clk);
      #1;
      push = 0; pop = 0; new_addr = '0; branch_fetched = 0; branch_retired = 0; flush = 0;
   endtask
   initial begin
      #12;
      chk("rst_addr", addr, 32'h0);
      chk("rst_count", 32'(dut.count_q), 0);
      chk("rst_inflight", 32'(dut.inflight_q), 0);
      chk("rst_index", 32'(dut.read_index_q), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      step(1, 0, 32'h100, 0, 0, 0);
      step(1, 0, 32'h200, 0, 0, 0);
      chk("push2_addr", addr, 32'h200);
      step(0, 1, 0, 0, 0, 0);
      chk("pop1_addr", addr, 32'h100);
      step(0, 1, 0, 0, 0, 0);
      chk("pop2_addr", addr, 32'h0);
      chk("pop2_count", 32'(dut.count_q), 0);
      step(0, 1, 0, 0, 0, 0);
      chk("empty_pop_addr", addr, 32'h0);
      chk("empty_pop_index", 32'(dut.read_index_q), 0);
      step(1, 0, 32'h40, 0, 0, 0);
      chk("push40_addr", addr, 32'h40);
      step(0, 1, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) step(1, 0, 32'(i), 0, 0, 0);
      chk("wrap_addr", addr, 32'h9);
      chk("wrap_count", 32'(dut.count_q), 8);
      for (int i = 8; i >= 2; i--) begin
         step(0, 1, 0, 0, 0, 0);
         chk($sformatf("wrap_pop_%0d", i), addr, 32'(i));
      end
      step(0, 1, 0, 0, 0, 0);
      chk("wrap_empty_addr", addr, 32'h0);
      chk("wrap_empty_count", 32'(dut.count_q), 0);
      step(1, 0, 32'hA0, 0, 0, 0);
      step(1, 1, 32'hB0, 0, 0, 0);
      chk("pushpop_addr", addr, 32'hB0);
      chk("pushpop_count", 32'(dut.count_q), 1);
      step(0, 1, 0, 0, 0, 0);
      chk("pushpop_pop_addr", addr, 32'h0);
      step(1, 0, 32'h10, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("ckpt_inflight", 32'(dut.inflight_q), 1);
      step(1, 0, 32'h20, 0, 0, 0);
      step(1, 0, 32'h30, 0, 0, 0);
      chk("spec_addr", addr, 32'h30);
      step(1, 1, 32'h77, 0, 0, 1);
`ifdef RAS_CHECKPOINT_EN
      chk("flush_addr", addr, 32'h10);
      chk("flush_count", 32'(dut.count_q), 1);
`else
      chk("flush_addr", addr, 32'h30);
      chk("flush_count", 32'(dut.count_q), 3);
`endif
      chk("flush_inflight", 32'(dut.inflight_q), 0);
      step(0, 0, 0, 0, 0, 1);
      chk("flush_idle_inflight", 32'(dut.inflight_q), 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
      chk("inflight_sat", 32'(dut.inflight_q), 4);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      chk("inflight_both", 32'(dut.inflight_q), 3);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
      chk("inflight_zero", 32'(dut.inflight_q), 0);
      step(1, 0, 32'h55, 0, 0, 0);
      chk("pre_reset_addr", addr, 32'h55);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("async_rst_addr", addr, 32'h0);
      chk("async_rst_count", 32'(dut.count_q), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
